inst_encoder: RTL and testbench

Streaming instruction encoder. It is the inverse of the pipeline's instruction decoder: it accepts opcode, register and immediate fields over a valid/ready handshake, packs them into 16-bit instruction words, and range-checks each immediate or displacement. Each word is emitted together with an auto-incrementing instruction-memory byte address. It sits between the test/program-load front end and the instruction-memory write port.

---
 rtl/inst_encoder_if.sv | 39 +++
 rtl/inst_encoder.sv | 181 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Bundle-in / word-out handshake and address-load signals of the instruction encoder.
// The encoder takes the slave modport; the program-load front end takes master.
interface inst_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              load_base;
  logic [ADDR_W-1:0] base_addr;

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [2:0]        rd;
  logic [1:0]        func;
  logic [15:0]       imm;

  logic              out_valid;
  logic              out_ready;
  logic [15:0]       inst;
  logic [ADDR_W-1:0] addr;
  logic              err;
  logic [7:0]        err_cnt;
  logic              busy;

  modport master (
    output load_base, base_addr,
    output in_valid, op, rs, rt, rd, func, imm,
    output out_ready,
    input  in_ready, out_valid, inst, addr, err, err_cnt, busy
  );

  modport slave (
    input  load_base, base_addr,
    input  in_valid, op, rs, rt, rd, func, imm,
    input  out_ready,
    output in_ready, out_valid, inst, addr, err, err_cnt, busy
  );
endinterface

// File: rtl/inst_encoder.sv
// Two-stage streaming instruction encoder: S1 captures fields and classifies the opcode,
// S2 packs and range-checks the 16-bit word and pairs it with its byte address.
module inst_encoder #(
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    F_NONE,
    F_I5S,
    F_I5U,
    F_I8U,
    F_I8S,
    F_R1,
    F_R,
    F_J
  } fmt_t;

  fmt_t              fmt_in;

  logic              s1_valid;
  fmt_t              s1_fmt;
  logic [4:0]        s1_op;
  logic [2:0]        s1_rs;
  logic [2:0]        s1_rt;
  logic [2:0]        s1_rd;
  logic [1:0]        s1_func;
  logic [15:0]       s1_imm;

  logic              out_valid_q;
  logic [15:0]       inst_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_cnt_q;

  logic [15:0]       pk_inst;
  logic              pk_err;

  logic              out_fire;
  logic              s1_advance;
  logic              in_ready;
  logic              accept;
  logic              busy;

  assign out_fire   = out_valid_q && bus.out_ready;
  assign s1_advance = s1_valid && (!out_valid_q || bus.out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = bus.in_valid && in_ready;
  assign busy       = s1_valid || out_valid_q;

  // Opcode-to-format map; patterns are kept disjoint so ordering does not matter.
  always_comb begin
    fmt_in = F_NONE;
    casez (bus.op)
      5'b000??:          fmt_in = F_NONE;
      5'b00100, 5'b00110: fmt_in = F_J;
      5'b00101, 5'b00111: fmt_in = F_I8S;
      5'b0100?:          fmt_in = F_I5S;
      5'b0101?:          fmt_in = F_I5U;
      5'b011??:          fmt_in = F_I8S;
      5'b1000?:          fmt_in = F_I5S;
      5'b10010:          fmt_in = F_I8U;
      5'b10011:          fmt_in = F_I5S;
      5'b101??:          fmt_in = F_I5S;
      5'b11000:          fmt_in = F_I8S;
      5'b11001:          fmt_in = F_R1;
      5'b1101?:          fmt_in = F_R;
      5'b111??:          fmt_in = F_R;
      default:           fmt_in = F_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= F_NONE;
      s1_op    <= '0;
      s1_rs    <= '0;
      s1_rt    <= '0;
      s1_rd    <= '0;
      s1_func  <= '0;
      s1_imm   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_fmt  <= fmt_in;
        s1_op   <= bus.op;
        s1_rs   <= bus.rs;
        s1_rt   <= bus.rt;
        s1_rd   <= bus.rd;
        s1_func <= bus.func;
        s1_imm  <= bus.imm;
      end
    end
  end

  // Out-of-range fields are still packed from their low bits; only err flags them.
  always_comb begin
    pk_inst = {s1_op, 11'b0};
    pk_err  = 1'b0;
    case (s1_fmt)
      F_I5S: begin
        pk_inst[10:0] = {s1_rs, s1_rd, s1_imm[4:0]};
        pk_err        = (s1_imm[15:4] != '0) && (s1_imm[15:4] != '1);
      end
      F_I5U: begin
        pk_inst[10:0] = {s1_rs, s1_rd, s1_imm[4:0]};
        pk_err        = (s1_imm[15:5] != '0);
      end
      F_I8U: begin
        pk_inst[10:0] = {s1_rs, s1_imm[7:0]};
        pk_err        = (s1_imm[15:8] != '0);
      end
      F_I8S: begin
        pk_inst[10:0] = {s1_rs, s1_imm[7:0]};
        pk_err        = (s1_imm[15:7] != '0) && (s1_imm[15:7] != '1);
      end
      F_R1: begin
        pk_inst[10:0] = {s1_rs, 3'b000, s1_rd, s1_func};
      end
      F_R: begin
        pk_inst[10:0] = {s1_rs, s1_rt, s1_rd, s1_func};
      end
      F_J: begin
        pk_inst[10:0] = s1_imm[10:0];
        pk_err        = (s1_imm[15:10] != '0) && (s1_imm[15:10] != '1);
      end
      default: begin
        pk_inst[10:0] = 11'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      err_q       <= 1'b0;
    end else if (s1_advance) begin
      out_valid_q <= 1'b1;
      inst_q      <= pk_inst;
      err_q       <= pk_err;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // The counter is the address of the word in S2; a load can only land while idle,
  // so it never competes with a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (bus.load_base && !busy) begin
      addr_q <= {bus.base_addr[ADDR_W-1:1], 1'b0};
    end else if (out_fire) begin
      addr_q <= addr_q + ADDR_W'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_fire && err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.inst      = inst_q;
  assign bus.addr      = addr_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a vector table of field bundles with hand-packed words,
// then streaming sequences for back-to-back, backpressure/wrap, ignored load and reset.
module tb_inst_encoder;

  logic clk;
  logic rst_n;

  inst_encoder_if #(.ADDR_W(16)) bus ();

  inst_encoder #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [1:0]  func;
    logic [15:0] imm;
    logic [15:0] inst;
    logic        err;
  } vec_t;

  vec_t        vec[16];
  int          total;
  int          bad;
  logic [15:0] exp_addr;
  logic [7:0]  exp_ecnt;
  int          span;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.op   = vec[i].op;
    bus.rs   = vec[i].rs;
    bus.rt   = vec[i].rt;
    bus.rd   = vec[i].rd;
    bus.func = vec[i].func;
    bus.imm  = vec[i].imm;
  endtask

  // Streams vec[first .. first+n-1]; out_ready follows rdy bit per cycle, load_base
  // pulses on cycle load_at. Checks every emitted word, hold stability and capacity.
  task automatic stream(input int first, input int n, input logic [31:0] rdy,
                        input int load_at, input logic [15:0] load_val, output int sp);
    int          sent;
    int          got;
    int          infl;
    int          first_c;
    int          last_c;
    logic        acc;
    logic        hs;
    logic        hold;
    logic [15:0] p_inst;
    logic [15:0] p_addr;
    logic        p_err;
    sent = 0; got = 0; infl = 0; first_c = -1; last_c = -1;
    hold = 1'b0; p_inst = '0; p_addr = '0; p_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = (c < 32) ? rdy[c[4:0]] : 1'b1;
      bus.load_base = (c == load_at);
      bus.base_addr = load_val;
      if (sent < n) begin
        drive(first + sent);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk("stream busy", 32'(bus.busy), 32'(infl != 0));
      if (hold) begin
        chk("hold inst", 32'(bus.inst), 32'(p_inst));
        chk("hold addr", 32'(bus.addr), 32'(p_addr));
        chk("hold err", 32'(bus.err), 32'(p_err));
      end
      if (infl == 2 && !bus.out_ready) chk("full in_ready", 32'(bus.in_ready), 0);
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      if (hs) begin
        chk($sformatf("stream inst v%0d", first + got), 32'(bus.inst), 32'(vec[first + got].inst));
        chk($sformatf("stream err v%0d", first + got), 32'(bus.err), 32'(vec[first + got].err));
        chk($sformatf("stream addr v%0d", first + got), 32'(bus.addr), 32'(exp_addr));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus.load_base && infl == 0) exp_addr = {load_val[15:1], 1'b0};
      hold   = bus.out_valid && !bus.out_ready;
      p_inst = bus.inst;
      p_addr = bus.addr;
      p_err  = bus.err;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        infl++;
      end
      if (hs) begin
        infl--;
        exp_addr = exp_addr + 16'd2;
        if (vec[first + got].err && exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
        got++;
      end
      chk("stream err_cnt", 32'(bus.err_cnt), 32'(exp_ecnt));
      if (got == n) break;
    end
    bus.in_valid  = 1'b0;
    bus.load_base = 1'b0;
    chk("stream count", got, n);
    chk("stream drained", 32'(bus.busy), 0);
    sp = last_c - first_c;
  endtask

  initial begin
    //          op        rs    rt    rd    func  imm       inst      err
    vec[0]  = '{5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFFD, 16'h415D, 1'b0};
    vec[1]  = '{5'b11011, 3'd3, 3'd4, 3'd5, 2'd2, 16'h0000, 16'hDB96, 1'b0};
    vec[2]  = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFE, 16'h27FE, 1'b0};
    vec[3]  = '{5'b10010, 3'd6, 3'd0, 3'd0, 2'd0, 16'h01FF, 16'h96FF, 1'b1};
    vec[4]  = '{5'b01010, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0020, 16'h5000, 1'b1};
    vec[5]  = '{5'b00011, 3'd7, 3'd7, 3'd7, 2'd3, 16'hFFFF, 16'h1800, 1'b0};
    vec[6]  = '{5'b11001, 3'd2, 3'd5, 3'd3, 2'd1, 16'h1234, 16'hCA0D, 1'b0};
    vec[7]  = '{5'b11000, 3'd1, 3'd0, 3'd0, 2'd0, 16'hFF80, 16'hC180, 1'b0};
    vec[8]  = '{5'b01100, 3'd4, 3'd0, 3'd0, 2'd0, 16'h0080, 16'h6480, 1'b1};
    vec[9]  = '{5'b10100, 3'd5, 3'd0, 3'd6, 2'd0, 16'h000F, 16'hA5CF, 1'b0};
    vec[10] = '{5'b10000, 3'd0, 3'd0, 3'd1, 2'd0, 16'hFFEF, 16'h802F, 1'b1};
    vec[11] = '{5'b00110, 3'd0, 3'd0, 3'd3, 2'd0, 16'h03FF, 16'h33FF, 1'b0};
    vec[12] = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFBFF, 16'h23FF, 1'b1};
    vec[13] = '{5'b10010, 3'd0, 3'd0, 3'd0, 2'd0, 16'h00FF, 16'h90FF, 1'b0};
    vec[14] = '{5'b01011, 3'd1, 3'd0, 3'd1, 2'd0, 16'h001F, 16'h593F, 1'b0};
    vec[15] = '{5'b00101, 3'd7, 3'd0, 3'd0, 2'd0, 16'h007F, 16'h2F7F, 1'b0};

    total = 0; bad = 0; exp_addr = '0; exp_ecnt = '0; span = 0;
    rst_n = 1'b0;
    bus.load_base = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0;
    bus.op = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.func = '0; bus.imm = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 1);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset addr", 32'(bus.addr), 0);
    chk("reset err_cnt", 32'(bus.err_cnt), 0);
    chk("reset inst", 32'(bus.inst), 0);
    chk("reset err", 32'(bus.err), 0);
    chk("reset busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One bundle at a time: accept at edge N, word visible after N+1, handshake at N+2.
    for (int i = 0; i < 16; i++) begin
      drive(i);
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk($sformatf("tbl%0d early out_valid", i), 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d out_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("tbl%0d inst", i), 32'(bus.inst), 32'(vec[i].inst));
      chk($sformatf("tbl%0d err", i), 32'(bus.err), 32'(vec[i].err));
      chk($sformatf("tbl%0d addr", i), 32'(bus.addr), 32'(exp_addr));
      @(posedge clk); #1;
      exp_addr = exp_addr + 16'd2;
      if (vec[i].err && exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
      chk($sformatf("tbl%0d err_cnt", i), 32'(bus.err_cnt), 32'(exp_ecnt));
      chk($sformatf("tbl%0d drained", i), 32'(bus.out_valid), 0);
    end
    chk("tbl final err_cnt", 32'(bus.err_cnt), 5);

    // Back-to-back, out_ready held high: four words on four consecutive cycles.
    stream(0, 4, 32'hFFFF_FFFF, -1, 16'h0000, span);
    chk("b2b span", span, 3);

    // Load 0xFFFC in the same idle cycle as the first bundle, stall 4 cycles, wrap.
    stream(3, 3, 32'hFFFF_FFF0, 0, 16'hFFFC, span);
    chk("wrap counter", 32'(bus.addr), 32'h0002);

    // Load while busy is dropped; counter keeps counting from 0x0002.
    stream(6, 3, 32'hFFFF_FFFF, 1, 16'h0100, span);
    chk("ignored load counter", 32'(bus.addr), 32'h0008);

    // Asynchronous reset with two bundles in flight.
    bus.out_ready = 1'b0;
    drive(0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    chk("pre-reset out_valid", 32'(bus.out_valid), 1);
    chk("pre-reset in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(bus.out_valid), 0);
    chk("async err_cnt", 32'(bus.err_cnt), 0);
    chk("async addr", 32'(bus.addr), 0);
    chk("async in_ready", 32'(bus.in_ready), 1);
    chk("async busy", 32'(bus.busy), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    exp_addr = '0;
    exp_ecnt = '0;
    @(posedge clk); #1;
    stream(1, 1, 32'hFFFF_FFFF, -1, 16'h0000, span);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
